// File: rtl/mips_pkg.sv
// Shared definitions for the ID/EX pipeline boundary: ALU opcodes, the decoded
// control bundle, the EX register image and its bubble constant.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } alu_op_e;

  localparam int unsigned CTRL_W       = 12;
  localparam int unsigned BUBBLE_CNT_W = 16;
  localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_CNT_MAX = '1;

  // Field order fixes the 12-bit packing: halt is the MSB, alu_op the low nibble.
  typedef struct packed {
    logic       halt;
    logic       mem_to_reg;
    logic       mem_write;
    logic       beq;
    logic       bne;
    logic       alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    ctrl_t       ctrl;
  } ex_regs_t;

  // A bubble is all-zero: invalid, no side-effecting controls, no data.
  localparam ex_regs_t EX_BUBBLE = '0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  function automatic logic [4:0] dest_reg(input logic reg_dst,
                                          input logic [4:0] rd,
                                          input logic [4:0] rt);
    return reg_dst ? rd : rt;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction being decoded in ID.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_to_reg,
  input  logic [4:0] ex_wreg,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       halted,
  output logic       stall
);

  logic src_match;

  assign src_match = (ex_wreg == id_rs) || (ex_wreg == id_rt);

  // $zero is never really written, so a load targeting it cannot create a hazard.
  assign stall = ex_valid && ex_mem_to_reg && (ex_wreg != 5'd0) &&
                 id_valid && src_match && !halted;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush, sticky halt and a
// saturating count of inserted bubbles.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_l,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        Halt,
  input  logic        MemtoReg,
  input  logic        MemWrite,
  input  logic        Beq,
  input  logic        Bne,
  input  logic        AluSrcB,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic [3:0]  AluOP,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic        ex_Halt,
  output logic        ex_MemtoReg,
  output logic        ex_MemWrite,
  output logic        ex_Beq,
  output logic        ex_Bne,
  output logic        ex_AluSrcB,
  output logic        ex_RegWrite,
  output logic        ex_RegDst,
  output logic [3:0]  ex_AluOP,
  output logic [4:0]  ex_wreg,
  output logic        stall,
  output logic        halted,
  output logic [15:0] bubble_cnt
);

  state_e                  state_q, state_d;
  ex_regs_t                ex_q, ex_d, id_img;
  logic [CTRL_W-1:0]       id_ctrl;
  logic [BUBBLE_CNT_W-1:0] cnt_q, cnt_d;

  assign id_ctrl = {Halt, MemtoReg, MemWrite, Beq, Bne, AluSrcB, RegWrite, RegDst, AluOP};

  assign id_img = '{
    valid:   id_valid,
    pc:      id_pc,
    rs_data: id_rs_data,
    rt_data: id_rt_data,
    imm:     id_imm,
    rs:      id_rs,
    rt:      id_rt,
    wreg:    dest_reg(RegDst, id_rd, id_rt),
    ctrl:    ctrl_t'(id_ctrl)
  };

  assign halted = (state_q == ST_HALT);

  load_use_detect u_load_use_detect (
    .ex_valid      (ex_q.valid),
    .ex_mem_to_reg (ex_q.ctrl.mem_to_reg),
    .ex_wreg       (ex_q.wreg),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .halted        (halted),
    .stall         (stall)
  );

  // Priority per edge: halted > flush > stall > load.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    ex_d    = id_img;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_HALT: begin
        ex_d = EX_BUBBLE;
      end
      ST_RUN: begin
        if (flush || stall) begin
          ex_d = EX_BUBBLE;
          if (cnt_q != BUBBLE_CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else if (id_valid && Halt) begin
          state_d = ST_HALT;
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= ST_RUN;
      ex_q    <= EX_BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_wreg     = ex_q.wreg;
  assign ex_Halt     = ex_q.ctrl.halt;
  assign ex_MemtoReg = ex_q.ctrl.mem_to_reg;
  assign ex_MemWrite = ex_q.ctrl.mem_write;
  assign ex_Beq      = ex_q.ctrl.beq;
  assign ex_Bne      = ex_q.ctrl.bne;
  assign ex_AluSrcB  = ex_q.ctrl.alu_src_b;
  assign ex_RegWrite = ex_q.ctrl.reg_write;
  assign ex_RegDst   = ex_q.ctrl.reg_dst;
  assign ex_AluOP    = ex_q.ctrl.alu_op;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts the EX image for
// every driven cycle, the prediction is queued and compared after the edge.
module tb_id_ex_stage;

  localparam logic [11:0] C_HALT = 12'h800;
  localparam logic [11:0] C_MTR  = 12'h400;
  localparam logic [11:0] C_MW   = 12'h200;
  localparam logic [11:0] C_BEQ  = 12'h100;
  localparam logic [11:0] C_RW   = 12'h020;
  localparam logic [11:0] C_RD   = 12'h010;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic        flush;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic [11:0] ctrl;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_l;
  in_t  cur;
  exp_t m;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic        ex_valid, ex_Halt, ex_MemtoReg, ex_MemWrite, ex_Beq, ex_Bne;
  logic        ex_AluSrcB, ex_RegWrite, ex_RegDst, stall, halted;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic [3:0]  ex_AluOP;
  logic [15:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .id_valid    (cur.valid),
    .id_pc       (cur.pc),
    .id_rs_data  (cur.rs_data),
    .id_rt_data  (cur.rt_data),
    .id_imm      (cur.imm),
    .id_rs       (cur.rs),
    .id_rt       (cur.rt),
    .id_rd       (cur.rd),
    .Halt        (cur.ctrl[11]),
    .MemtoReg    (cur.ctrl[10]),
    .MemWrite    (cur.ctrl[9]),
    .Beq         (cur.ctrl[8]),
    .Bne         (cur.ctrl[7]),
    .AluSrcB     (cur.ctrl[6]),
    .RegWrite    (cur.ctrl[5]),
    .RegDst      (cur.ctrl[4]),
    .AluOP       (cur.ctrl[3:0]),
    .flush       (cur.flush),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_rs_data  (ex_rs_data),
    .ex_rt_data  (ex_rt_data),
    .ex_imm      (ex_imm),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_Halt     (ex_Halt),
    .ex_MemtoReg (ex_MemtoReg),
    .ex_MemWrite (ex_MemWrite),
    .ex_Beq      (ex_Beq),
    .ex_Bne      (ex_Bne),
    .ex_AluSrcB  (ex_AluSrcB),
    .ex_RegWrite (ex_RegWrite),
    .ex_RegDst   (ex_RegDst),
    .ex_AluOP    (ex_AluOP),
    .ex_wreg     (ex_wreg),
    .stall       (stall),
    .halted      (halted),
    .bubble_cnt  (bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  function automatic logic model_stall();
    return m.valid && m.ctrl[10] && (m.wreg != 5'd0) && cur.valid &&
           ((m.wreg == cur.rs) || (m.wreg == cur.rt)) && !m.halted;
  endfunction

  function automatic void model_reset();
    m = '0;
  endfunction

  // Advance the model by one edge using the currently driven inputs.
  function automatic void model_edge(input logic stl);
    if (m.halted) begin
      m = '{halted: 1'b1, cnt: m.cnt, default: '0};
    end else if (cur.flush || stl) begin
      m = '{halted: 1'b0, cnt: (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1, default: '0};
    end else begin
      m.valid   = cur.valid;
      m.pc      = cur.pc;
      m.rs_data = cur.rs_data;
      m.rt_data = cur.rt_data;
      m.imm     = cur.imm;
      m.rs      = cur.rs;
      m.rt      = cur.rt;
      m.wreg    = cur.ctrl[4] ? cur.rd : cur.rt;
      m.ctrl    = cur.ctrl;
      m.halted  = cur.valid && cur.ctrl[11];
    end
  endfunction

  task automatic compare_now(input string tag, input exp_t e);
    check({tag, ".valid"},   {31'd0, ex_valid}, {31'd0, e.valid});
    check({tag, ".pc"},      ex_pc, e.pc);
    check({tag, ".rs_data"}, ex_rs_data, e.rs_data);
    check({tag, ".rt_data"}, ex_rt_data, e.rt_data);
    check({tag, ".imm"},     ex_imm, e.imm);
    check({tag, ".rs_rt"},   {22'd0, ex_rs, ex_rt}, {22'd0, e.rs, e.rt});
    check({tag, ".wreg"},    {27'd0, ex_wreg}, {27'd0, e.wreg});
    check({tag, ".ctrl"},
          {20'd0, ex_Halt, ex_MemtoReg, ex_MemWrite, ex_Beq, ex_Bne,
           ex_AluSrcB, ex_RegWrite, ex_RegDst, ex_AluOP}, {20'd0, e.ctrl});
    check({tag, ".halted"},  {31'd0, halted}, {31'd0, e.halted});
    check({tag, ".cnt"},     {16'd0, bubble_cnt}, {16'd0, e.cnt});
  endtask

  // Drive one ID cycle, check the combinational stall, then check EX after the edge.
  task automatic step(input string tag, input in_t s);
    logic stl;
    exp_t e;
    @(negedge clk);
    cur = s;
    #1;
    stl = model_stall();
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, stl});
    model_edge(stl);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    check({tag, ".sb_depth"}, exp_q.size(), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      compare_now(tag, e);
    end
  endtask

  // Asynchronous reset pulse issued between edges with the given ID inputs held.
  task automatic reset_pulse(input string tag, input in_t s);
    @(negedge clk);
    cur = s;
    #1;
    check({tag, ".pre_stall"}, {31'd0, stall}, {31'd0, model_stall()});
    rst_l = 1'b0;
    #1;
    model_reset();
    compare_now({tag, ".async"}, m);
    check({tag, ".stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    compare_now({tag, ".held"}, m);
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  function automatic in_t instr(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [11:0] ctrl, input logic fl);
    return '{valid: 1'b1, pc: pc, rs_data: pc ^ 32'hA5A5_0000, rt_data: ~pc,
             imm: {pc[15:0], 16'h0F0F}, rs: rs, rt: rt, rd: rd, ctrl: ctrl, flush: fl};
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    in_t  s;
    logic [11:0] rc;
    rst_l = 1'b0;
    cur   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_now("reset", m);
    check("reset.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_l = 1'b1;

    // Plain load: RegDst selects rd.
    step("plain", instr(32'h4, 5'd1, 5'd3, 5'd5, C_RW | C_RD | 12'h3, 1'b0));

    // Load-use on rs: lw to r8, then a consumer of r8.
    step("lw8", instr(32'h8, 5'd2, 5'd8, 5'd0, C_MTR | C_RW | 12'h0, 1'b0));
    step("use_rs", instr(32'hC, 5'd8, 5'd4, 5'd9, C_RW | C_RD, 1'b0));
    step("use_rs_retry", instr(32'hC, 5'd8, 5'd4, 5'd9, C_RW | C_RD, 1'b0));

    // Load-use on rt.
    step("lw10", instr(32'h10, 5'd2, 5'd10, 5'd0, C_MTR | C_RW, 1'b0));
    step("use_rt", instr(32'h14, 5'd1, 5'd10, 5'd11, C_MW, 1'b0));

    // Zero register never stalls.
    step("lw0", instr(32'h18, 5'd2, 5'd0, 5'd0, C_MTR | C_RW, 1'b0));
    step("use_r0", instr(32'h1C, 5'd0, 5'd0, 5'd12, C_RW | C_RD, 1'b0));

    // Flush kills a store.
    step("flush_sw", instr(32'h20, 5'd3, 5'd4, 5'd0, C_MW | C_BEQ, 1'b1));

    // Flush and stall together count once.
    step("lw9", instr(32'h24, 5'd2, 5'd9, 5'd0, C_MTR | C_RW, 1'b0));
    step("flush_stall", instr(32'h28, 5'd9, 5'd9, 5'd13, C_RW | C_RD, 1'b1));

    // Invalid ID loads are not bubbles.
    s = instr(32'h2C, 5'd0, 5'd0, 5'd0, 12'h0, 1'b0);
    s.valid = 1'b0;
    step("idle", s);

    // Randomised mix, Halt masked off.
    for (int i = 0; i < 40; i++) begin
      rc = 12'($urandom) & ~C_HALT;
      s  = instr(32'h100 + 32'(i) * 4, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), rc, ($urandom_range(0, 7) == 0));
      s.valid = ($urandom_range(0, 5) != 0);
      step("rand", s);
    end

    // Halt: sticky, later instructions become uncounted bubbles.
    step("halt", instr(32'h200, 5'd1, 5'd2, 5'd3, C_HALT, 1'b0));
    step("post_halt0", instr(32'h204, 5'd1, 5'd2, 5'd3, C_RW | C_RD | C_MTR, 1'b0));
    step("post_halt1", instr(32'h208, 5'd3, 5'd3, 5'd3, C_MW, 1'b1));
    step("post_halt2", instr(32'h20C, 5'd3, 5'd3, 5'd3, C_BEQ, 1'b0));
    reset_pulse("rst_halt", instr(32'h210, 5'd1, 5'd2, 5'd3, C_RW, 1'b0));
    step("after_rst", instr(32'h214, 5'd6, 5'd7, 5'd8, C_MTR | C_RW | C_RD, 1'b0));

    // Reset while a stall is being requested.
    reset_pulse("rst_stall", instr(32'h218, 5'd8, 5'd1, 5'd2, C_RW, 1'b0));
    step("after_rst2", instr(32'h21C, 5'd8, 5'd1, 5'd2, C_RW | C_RD, 1'b0));

    // Saturation of the bubble counter.
    for (int i = 0; i < 65540; i++) begin
      step("sat", instr(32'h300, 5'd1, 5'd2, 5'd3, C_RW, 1'b1));
    end
    check("sat.final", {16'd0, bubble_cnt}, 32'h0000_FFFF);
    step("sat_load", instr(32'h304, 5'd1, 5'd2, 5'd3, C_RW | C_RD, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
